// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-port program-memory read arbiter.
package mem_arb_pkg;

  localparam int ADDR_W            = 8;
  localparam int DATA_W            = 8;
  localparam int CNT_W             = 4;
  localparam int MAX_BURST_DEFAULT = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic cnt_t sat_inc(input cnt_t value, input cnt_t limit);
    if (value >= limit) begin
      return limit;
    end else begin
      return value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled for port connection.
interface mem_arbiter_if import mem_arb_pkg::*; ();

  logic  req0Valid;
  addr_t req0Addr;
  logic  req0Lock;
  logic  req0Ready;
  logic  rsp0Valid;
  data_t rsp0Data;

  logic  req1Valid;
  addr_t req1Addr;
  logic  req1Lock;
  logic  req1Ready;
  logic  rsp1Valid;
  data_t rsp1Data;

  addr_t memAddr;
  logic  memStrobe;
  data_t memDataRead;

  modport slave (
    input  req0Valid, req0Addr, req0Lock, req1Valid, req1Addr, req1Lock, memDataRead,
    output req0Ready, rsp0Valid, rsp0Data, req1Ready, rsp1Valid, rsp1Data, memAddr, memStrobe
  );

  modport master (
    output req0Valid, req0Addr, req0Lock, req1Valid, req1Addr, req1Lock, memDataRead,
    input  req0Ready, rsp0Valid, rsp0Data, req1Ready, rsp1Valid, rsp1Data, memAddr, memStrobe
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational winner selection: bounded lock hold, then round-robin, then single requester.
module rr_pick2 import mem_arb_pkg::*; #(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_lock0,
  input  logic i_lock1,
  input  logic i_last_grant,
  input  cnt_t i_burst_cnt,
  output logic o_grant,
  output logic o_winner,
  output logic o_hold
);

  localparam cnt_t MAX_C = cnt_t'(MAX_BURST);

  logic w_last_locked;
  logic w_other_valid;
  logic w_hold_ok;

  // Lock is only broken once the burst is spent and the other port is actually waiting.
  always_comb begin
    w_last_locked = 1'b0;
    w_other_valid = 1'b0;
    if (i_last_grant == PORT_DBG) begin
      w_last_locked = i_valid1 & i_lock1;
      w_other_valid = i_valid0;
    end else begin
      w_last_locked = i_valid0 & i_lock0;
      w_other_valid = i_valid1;
    end
    w_hold_ok = w_last_locked & ((i_burst_cnt < MAX_C) | ~w_other_valid);
  end

  // Priority selection of the winner.
  always_comb begin
    o_grant  = 1'b0;
    o_winner = PORT_CPU;
    o_hold   = 1'b0;
    if (w_hold_ok) begin
      o_grant  = 1'b1;
      o_winner = i_last_grant;
      o_hold   = 1'b1;
    end else if (i_valid0 && i_valid1) begin
      o_grant  = 1'b1;
      o_winner = ~i_last_grant;
    end else if (i_valid0) begin
      o_grant  = 1'b1;
      o_winner = PORT_CPU;
    end else if (i_valid1) begin
      o_grant  = 1'b1;
      o_winner = PORT_DBG;
    end else begin
      o_grant  = 1'b0;
      o_winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port read arbiter in front of a synchronous-read program memory; returns each byte
// to the port whose request was granted in the previous cycle.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic          clk,
  input  logic          resetN,
  mem_arbiter_if.slave  bus
);

  logic r_last_grant;
  cnt_t r_burst_cnt;
  logic r_pend_valid;
  logic r_pend_id;

  logic w_grant;
  logic w_winner;
  logic w_hold;

  rr_pick2 #(.MAX_BURST(MAX_BURST)) u_pick (
    .i_valid0     (bus.req0Valid),
    .i_valid1     (bus.req1Valid),
    .i_lock0      (bus.req0Lock),
    .i_lock1      (bus.req1Lock),
    .i_last_grant (r_last_grant),
    .i_burst_cnt  (r_burst_cnt),
    .o_grant      (w_grant),
    .o_winner     (w_winner),
    .o_hold       (w_hold)
  );

  // Arbitration history and the single in-flight read tag.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_last_grant <= PORT_DBG;
      r_burst_cnt  <= 4'd0;
      r_pend_valid <= 1'b0;
      r_pend_id    <= PORT_CPU;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
      r_burst_cnt  <= (w_hold && (w_winner == r_last_grant))
                      ? sat_inc(r_burst_cnt, cnt_t'(MAX_BURST)) : 4'd1;
      r_pend_valid <= 1'b1;
      r_pend_id    <= w_winner;
    end else begin
      r_burst_cnt  <= 4'd0;
      r_pend_valid <= 1'b0;
    end
  end

  // Memory-side mux and request acceptance.
  always_comb begin
    bus.memStrobe = 1'b0;
    bus.memAddr   = 8'h00;
    bus.req0Ready = 1'b0;
    bus.req1Ready = 1'b0;
    if (w_grant) begin
      bus.memStrobe = 1'b1;
      if (w_winner == PORT_DBG) begin
        bus.memAddr   = bus.req1Addr;
        bus.req1Ready = 1'b1;
      end else begin
        bus.memAddr   = bus.req0Addr;
        bus.req0Ready = 1'b1;
      end
    end else begin
      bus.memStrobe = 1'b0;
      bus.memAddr   = 8'h00;
    end
  end

  // Steer the returning byte to the tagged port only; the other port sees zeros.
  always_comb begin
    bus.rsp0Valid = 1'b0;
    bus.rsp0Data  = 8'h00;
    bus.rsp1Valid = 1'b0;
    bus.rsp1Data  = 8'h00;
    if (r_pend_valid && (r_pend_id == PORT_DBG)) begin
      bus.rsp1Valid = 1'b1;
      bus.rsp1Data  = bus.memDataRead;
    end else if (r_pend_valid) begin
      bus.rsp0Valid = 1'b1;
      bus.rsp0Data  = bus.memDataRead;
    end else begin
      bus.rsp0Valid = 1'b0;
      bus.rsp1Valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a preloaded synchronous-read memory model.
module tb_mem_arbiter;

  logic clk;
  logic resetN;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    logic       vld;
    logic       id;
    logic [7:0] data;
  } rsp_t;

  rsp_t       sb[$];
  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (bus.memStrobe) bus.memDataRead <= mem[bus.memAddr];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] a0, input logic l0,
                       input logic v1, input logic [7:0] a1, input logic l1);
    bus.req0Valid = v0; bus.req0Addr = a0; bus.req0Lock = l0;
    bus.req1Valid = v1; bus.req1Addr = a1; bus.req1Lock = l1;
  endtask

  // One arbitration cycle: check last cycle's response, check this cycle's grant, queue expectation.
  task automatic cycle(input logic v0, input logic [7:0] a0, input logic l0,
                       input logic v1, input logic [7:0] a1, input logic l1,
                       input logic eg, input logic ew, input string tag);
    rsp_t e;
    logic [7:0] ea;
    @(negedge clk);
    drive(v0, a0, l0, v1, a1, l1);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp0v"}, {7'd0, bus.rsp0Valid}, {7'd0, e.vld && !e.id});
      chk({tag, "_rsp0d"}, bus.rsp0Data, (e.vld && !e.id) ? e.data : 8'h00);
      chk({tag, "_rsp1v"}, {7'd0, bus.rsp1Valid}, {7'd0, e.vld && e.id});
      chk({tag, "_rsp1d"}, bus.rsp1Data, (e.vld && e.id) ? e.data : 8'h00);
    end
    ea = eg ? (ew ? a1 : a0) : 8'h00;
    chk({tag, "_strobe"}, {7'd0, bus.memStrobe}, {7'd0, eg});
    chk({tag, "_addr"}, bus.memAddr, ea);
    chk({tag, "_rdy0"}, {7'd0, bus.req0Ready}, {7'd0, eg && !ew});
    chk({tag, "_rdy1"}, {7'd0, bus.req1Ready}, {7'd0, eg && ew});
    e.vld  = eg;
    e.id   = ew;
    e.data = ea ^ 8'hA5;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetN = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk({tag, "_rst_rsp0v"}, {7'd0, bus.rsp0Valid}, 8'h00);
    chk({tag, "_rst_rsp1v"}, {7'd0, bus.rsp1Valid}, 8'h00);
    chk({tag, "_rst_rsp0d"}, bus.rsp0Data, 8'h00);
    @(negedge clk);
    resetN = 1'b1;
    sb.delete();
    sb.push_back('{1'b0, 1'b0, 8'h00});
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      mem[i] = a ^ 8'hA5;
    end
    resetN = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state: responses quiet, request path still combinational.
    @(negedge clk);
    drive(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("reset_rsp0v", {7'd0, bus.rsp0Valid}, 8'h00);
    chk("reset_rsp0d", bus.rsp0Data, 8'h00);
    chk("reset_rsp1v", {7'd0, bus.rsp1Valid}, 8'h00);
    chk("reset_strobe", {7'd0, bus.memStrobe}, 8'h01);
    chk("reset_addr", bus.memAddr, 8'h33);
    chk("reset_rdy0", {7'd0, bus.req0Ready}, 8'h01);
    chk("reset_cnt", {4'd0, dut.r_burst_cnt}, 8'h00);
    do_reset("init");

    // Single port 0 read.
    cycle(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "p0only");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "p0only_idle");

    // Round-robin from reset: 0,1,0,1.
    do_reset("rr");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, i[0], "rr");
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rr_idle");

    // Port 1 locked against a waiting port 0: bursts of four, one port 0 grant between.
    do_reset("lock");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'h30, 1'b0, 1'b1, 8'h20, 1'b1, 1'b1, !(i == 4 || i == 9), "lock");
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "lock_idle");

    // Port 1 locked, port 0 idle: continuous grants, counter saturates.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b1, 1'b1, 1'b1, "sat");
    end
    chk("sat_cnt", {4'd0, dut.r_burst_cnt}, 8'h04);
    cycle(1'b1, 8'h50, 1'b0, 1'b1, 8'h4A, 1'b1, 1'b1, 1'b0, "sat_break");

    // Three idle cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
    end
    chk("idle_cnt", {4'd0, dut.r_burst_cnt}, 8'h00);

    // Reset while a port 0 read is in flight: response dropped, port 0 wins afterwards.
    cycle(1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "midrst");
    do_reset("midrst");
    cycle(1'b1, 8'h05, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0, "postrst");
    cycle(1'b1, 8'h05, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, "postrst");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "postrst_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
